// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared types and constants for the radix-2 DIT FFT control slice.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int CPLX_W    = 32;  // {re[15:0], im[15:0]}
  localparam int FRAC_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_addr_gen                                                         |
// | Maps (stage, butterfly) to operand pair and twiddle index.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int  N_LOG2  = 3,
  localparam int STAGE_W = (clog2(N_LOG2 + 1) < 1) ? 1 : clog2(N_LOG2 + 1),
  localparam int K_W     = (N_LOG2 > 1) ? N_LOG2 - 1 : 1,
  localparam int TW_W    = K_W
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [K_W-1:0]     k,
  output logic [N_LOG2-1:0]  rd_addr_a,
  output logic [N_LOG2-1:0]  rd_addr_b,
  output logic [TW_W-1:0]    tw_addr
);

  logic [N_LOG2-1:0]  k_ext;
  logic [N_LOG2-1:0]  half;
  logic [N_LOG2-1:0]  low;
  logic [TW_W-1:0]    tw_low;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    k_ext     = N_LOG2'(k);
    half      = N_LOG2'(1) << stage;
    low       = k_ext & (half - N_LOG2'(1));
    // Insert a zero at bit position s to split k into group and offset
    rd_addr_a = ((k_ext >> stage) << (stage + STAGE_W'(1))) | low;
    rd_addr_b = rd_addr_a + half;
    tw_shift  = STAGE_W'(N_LOG2 - 1) - stage;
    tw_low    = TW_W'(low);
    tw_addr   = tw_low << tw_shift;
  end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_stage_sequencer                                                  |
// | Stage/butterfly sequencer with write-back delay line for in-place    |
// | radix-2 DIT FFT. Optional FFT_INVERSE_EN adds inverse / tw_conj.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int  N_LOG2      = 3,
  parameter int  MAU_LATENCY = 2,
  localparam int STAGE_W     = (clog2(N_LOG2 + 1) < 1) ? 1 : clog2(N_LOG2 + 1),
  localparam int K_W         = (N_LOG2 > 1) ? N_LOG2 - 1 : 1,
  localparam int TW_W        = K_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [N_LOG2-1:0]  rd_addr_a,
  output logic [N_LOG2-1:0]  rd_addr_b,
  output logic [TW_W-1:0]    tw_addr,
  output logic               mau_valid,
  output logic               wr_en,
  output logic [N_LOG2-1:0]  wr_addr_a,
  output logic [N_LOG2-1:0]  wr_addr_b,
  output logic [STAGE_W-1:0] stage
`ifdef FFT_INVERSE_EN
  ,
  input  logic               inverse,
  output logic               tw_conj
`endif
);

  localparam int DLY   = 1 + MAU_LATENCY;
  localparam int ENT_W = 2 * N_LOG2 + 1;
  localparam int CNT_W = (clog2(DLY) < 1) ? 1 : clog2(DLY);

  localparam logic [K_W-1:0]     K_LAST     = K_W'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAU_LATENCY);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);

  fft_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [N_LOG2-1:0]  rd_addr_a_q, rd_addr_a_d;
  logic [N_LOG2-1:0]  rd_addr_b_q, rd_addr_b_d;
  logic [TW_W-1:0]    tw_addr_q, tw_addr_d;
  logic [DLY-1:0][ENT_W-1:0] dly_q, dly_d;
`ifdef FFT_INVERSE_EN
  logic               tw_conj_q, tw_conj_d;
`endif

  // Addresses are generated for the butterfly about to be registered
  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .stage     (stage_d),
    .k         (k_d),
    .rd_addr_a (rd_addr_a_d),
    .rd_addr_b (rd_addr_b_d),
    .tw_addr   (tw_addr_d)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
`ifdef FFT_INVERSE_EN
    tw_conj_d = tw_conj_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
`ifdef FFT_INVERSE_EN
          tw_conj_d = inverse;
`endif
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d     = k_q + K_W'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        // Hold off the next stage until its last write-back has landed
        if (cnt_q == CNT_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + STAGE_W'(1);
            k_d     = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    dly_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
    for (int i = 1; i < DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      dly_q       <= '0;
`ifdef FFT_INVERSE_EN
      tw_conj_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      dly_q       <= dly_d;
`ifdef FFT_INVERSE_EN
      tw_conj_q   <= tw_conj_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign stage     = stage_q;
  assign mau_valid = dly_q[0][ENT_W-1];
  assign wr_en     = dly_q[DLY-1][ENT_W-1];
  assign wr_addr_a = dly_q[DLY-1][2*N_LOG2-1:N_LOG2];
  assign wr_addr_b = dly_q[DLY-1][N_LOG2-1:0];
`ifdef FFT_INVERSE_EN
  assign tw_conj   = tw_conj_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_stage_sequencer                                               |
// | Scoreboard bench: N=8, MAU_LATENCY=2, with RAM/ROM/butterfly model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int NLOG       = 3;
  localparam int LAT        = 2;
  localparam int NPTS       = 8;
  localparam int HALF       = 4;
  localparam int PERIOD     = HALF + 1 + LAT;
  localparam int DONE_CYC   = 1 + NLOG * PERIOD;
  localparam int RUN_CYCLES = DONE_CYC + 3;
  localparam int BFLY       = NLOG * HALF;

  localparam int EXP_A  [BFLY] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int EXP_B  [BFLY] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int EXP_TW [BFLY] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, mau_valid, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [1:0] stage;
`ifdef FFT_INVERSE_EN
  logic       inverse = 1'b0;
  logic       tw_conj;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] rd_q[$];
  logic [63:0] wr_q[$];

  always #5 Clk = ~Clk;

  fft_stage_sequencer #(
    .N_LOG2      (NLOG),
    .MAU_LATENCY (LAT)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .mau_valid (mau_valid),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
`ifdef FFT_INVERSE_EN
    ,
    .inverse   (inverse),
    .tw_conj   (tw_conj)
`endif
  );

  // RAM with one-cycle read, twiddle ROM and a 2-cycle butterfly unit
  logic        ram_init = 1'b0;
  logic [CPLX_W-1:0] ram [NPTS];
  logic [CPLX_W-1:0] op_a, op_b, op_w, p_y, p_z, y_q, z_q;

  function automatic logic [31:0] tw_rom(input logic [1:0] t);
    case (t)
      2'd0:    return {16'h0400, 16'h0000};
      2'd1:    return {16'h02D4, 16'hFD2C};
      2'd2:    return {16'h0000, 16'hFC00};
      default: return {16'hFD2C, 16'hFD2C};
    endcase
  endfunction

  function automatic logic [31:0] cmul(input logic [31:0] w, input logic [31:0] b);
    int wr, wi, br, bi, pr, pi;
    wr = int'($signed(w[31:16]));
    wi = int'($signed(w[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    pr = (wr * br - wi * bi) >>> FRAC_BITS;
    pi = (wr * bi + wi * br) >>> FRAC_BITS;
    return {pr[15:0], pi[15:0]};
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
    return {a[31:16] + b[31:16], a[15:0] + b[15:0]};
  endfunction

  function automatic logic [31:0] csub(input logic [31:0] a, input logic [31:0] b);
    return {a[31:16] - b[31:16], a[15:0] - b[15:0]};
  endfunction

  always @(posedge Clk) begin
    if (ram_init) begin
      for (int i = 0; i < NPTS; i++) ram[i] <= (i == 0) ? 32'h0400_0000 : 32'h0;
    end else if (wr_en) begin
      ram[wr_addr_a] <= y_q;
      ram[wr_addr_b] <= z_q;
    end
    if (rd_en) begin
      op_a <= ram[rd_addr_a];
      op_b <= ram[rd_addr_b];
      op_w <= tw_rom(tw_addr);
    end
    if (mau_valid) begin
      p_y <= cadd(op_a, cmul(op_w, op_b));
      p_z <= csub(op_a, cmul(op_w, op_b));
    end
    y_q <= p_y;
    z_q <= p_z;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_rd(input int c, input int s, input int a,
                                          input int b, input int t);
    return {c[15:0], s[7:0], a[7:0], b[7:0], t[7:0], 16'h0000};
  endfunction

  function automatic logic [63:0] pack_wr(input int c, input int a, input int b);
    return {c[31:0], a[7:0], b[7:0], 16'h0000};
  endfunction

  function automatic bit rd_act(input int r);
    if (r < 1) return 1'b0;
    return ((r - 1) / PERIOD < NLOG) && ((r - 1) % PERIOD < HALF);
  endfunction

  // One FFT run; pulse_*/rst_at are relative cycles (-1 = unused)
  task automatic run_fft(input int pulse_a, input int pulse_b, input int rst_at);
    int n_done;
    int cyc;
    n_done = 0;
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < BFLY; i++) begin
      cyc = 1 + (i / HALF) * PERIOD + (i % HALF);
      rd_q.push_back(pack_rd(cyc, i / HALF, EXP_A[i], EXP_B[i], EXP_TW[i]));
      wr_q.push_back(pack_wr(cyc + 1 + LAT, EXP_A[i], EXP_B[i]));
    end
    @(negedge Clk);
    start = 1'b1;
    for (int rel = 1; rel <= RUN_CYCLES; rel++) begin
      @(negedge Clk);
      start = (rel + 1 == pulse_a) || (rel + 1 == pulse_b);
      Rst   = (rel + 1 == rst_at);
      if (rel == rst_at) begin
        check("abort_strobes", {busy, done, rd_en, mau_valid, wr_en}, 64'h0);
        check("abort_addrs", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage}, 64'h0);
        rd_q.delete();
        wr_q.delete();
        for (int j = 0; j < 6; j++) begin
          @(negedge Clk);
          check("abort_quiet", {busy, done, rd_en, wr_en}, 64'h0);
        end
        return;
      end
      check("busy", busy, rel <= DONE_CYC);
      check("done", done, rel == DONE_CYC);
      check("rd_en", rd_en, rd_act(rel));
      check("mau_valid", mau_valid, rd_act(rel - 1));
      check("wr_en", wr_en, rd_act(rel - 1 - LAT));
      if (done) n_done++;
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", rd_en, 64'h0);
        else check("rd_op", pack_rd(rel, stage, rd_addr_a, rd_addr_b, tw_addr), rd_q.pop_front());
`ifdef FFT_INVERSE_EN
        check("tw_conj", tw_conj, inverse);
`endif
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", wr_en, 64'h0);
        else check("wr_op", pack_wr(rel, wr_addr_a, wr_addr_b), wr_q.pop_front());
      end
    end
    check("done_count", n_done, 64'd1);
    check("rd_left", rd_q.size(), 64'd0);
    check("wr_left", wr_q.size(), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_strobes", {busy, done, rd_en, mau_valid, wr_en}, 64'h0);
    check("reset_addrs", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage}, 64'h0);

    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    Rst   = 1'b0;
    check("rst_wins", busy, 64'h0);
    @(negedge Clk);
    check("rst_wins_idle", {busy, rd_en}, 64'h0);

    ram_init = 1'b1;
    @(negedge Clk);
    ram_init = 1'b0;
    run_fft(-1, -1, -1);
    for (int i = 0; i < NPTS; i++) check($sformatf("bin%0d", i), ram[i], 64'h0400_0000);

    run_fft(5, 15, -1);
    run_fft(-1, -1, 10);
`ifdef FFT_INVERSE_EN
    inverse = 1'b1;
`endif
    run_fft(-1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
